shake_squeeze: RTL and testbench
================================

Name: shake_squeeze

Overview:
- Output-side counterpart of the SHAKE256 input padder. It takes the 1088-bit rate portion of the Keccak state after each permutation and emits it as a byte stream with valid/ready handshaking.
- It requests further permutations until the caller-specified output length has been produced.
- It sits between the Keccak round core (block source) and the digest consumer.

Parameters:
- RANGE, 1088, rate width in bits. Must be a multiple of 8.
- LEN_W, 16, width of the requested-length input in bytes. Maximum output is 2^LEN_W−1 bytes.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- squeeze_start  in  1  starts a squeeze; sampled only in IDLE.
- out_len  in  LEN_W  number of output bytes requested; captured with squeeze_start.
- block_in  in  RANGE  rate bits from the permutation. Byte 0 is block_in[RANGE-1 -: 8]; byte k is block_in[RANGE-1-8k -: 8].
- block_valid  in  1  block_in is valid; sampled only in WAIT_BLOCK.
- perm_req  out  1  one-cycle pulse requesting the next permutation.
- out_byte  out  8  current output byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts the byte.
- squeeze_done  out  1  one-cycle pulse after the final byte is accepted.
- busy  out  1  high in any state other than IDLE.
- debug_state  out  3  current FSM state.
- debug_bytecount  out  11  bytes accepted from the current block (0..RANGE/8).

Behaviour:
- Reset (synchronous, including mid-operation):
  - State goes to IDLE.
  - perm_req, out_valid, squeeze_done and busy go to 0.
  - out_byte, debug_bytecount, the latched block, the remaining-byte counter and the byte index all clear to 0.
  - debug_state goes to 0.
- All outputs are registered.
- State encodings: IDLE=0, WAIT_BLOCK=1, EMIT=2, REQ=3, DONE=4.
- IDLE:
  - squeeze_start with out_len>0: latch out_len into remaining, go to WAIT_BLOCK.
  - squeeze_start with out_len==0: go to DONE.
  - No perm_req is issued for the first block; the absorb path delivers it.
- WAIT_BLOCK:
  - On block_valid: latch block_in, set byte_idx=0, debug_bytecount=0, go to EMIT.
  - out_valid rises in the cycle after block_valid is sampled, with out_byte = byte 0. Latency is 1 clock.
  - block_valid outside WAIT_BLOCK is ignored.
- EMIT:
  - out_valid=1 and out_byte = latched byte[byte_idx].
  - Handshake occurs when out_valid && out_ready. On a handshake: remaining−1, byte_idx+1, debug_bytecount+1, and the next byte is presented the following cycle with no bubble.
  - Without out_ready, out_byte and out_valid are held stable.
  - Handshake on a byte with remaining==1: out_valid drops, go to DONE. This applies even if that byte is also the last of the block; last-byte-of-output takes priority, so no perm_req is issued.
  - Handshake on byte RANGE/8−1 with remaining>1: out_valid drops, go to REQ.
- REQ: assert perm_req for exactly one cycle, then go to WAIT_BLOCK.
- DONE: assert squeeze_done for exactly one cycle (busy still 1), then go to IDLE.
- squeeze_start outside IDLE is ignored.
- A new squeeze may start in the cycle after squeeze_done.
- Arithmetic:
  - remaining is LEN_W bits unsigned and never decrements below 1 while in EMIT.
  - byte_idx is ceil(log2(RANGE/8)) bits, range 0..RANGE/8−1.
- Implementation may use a shift-left-by-8 register in place of the byte-index mux; the output ordering must be identical.

Decomposition:
- Shared package shake_pkg holds:
  - RATE_BITS=1088 and RATE_BYTES=136;
  - squeeze state encodings;
  - LEN_W default.
- The padder and this block both import shake_pkg.
- One sub-module is natural: shake_rate_byte_sel, a combinational RANGE-to-byte selector indexed by byte_idx. Everything else lives in one FSM module.

Test Plan:
- 1. out_len=4, block = 0x80, 131×0x00, 0x1F, 0x63, 0x62, 0x61; out_ready=1 → bytes 80, 00, 00, 00 on consecutive cycles, then squeeze_done one cycle later; perm_req never asserted.
- 2. out_len=136, same block → all 136 bytes in order, last four 1F 63 62 61; no perm_req; squeeze_done pulses once; debug_bytecount ends at 136.
- 3. out_len=140, first block bytes k=k[7:0], second block bytes 0xA0+k → 136 bytes 00..87, one perm_req pulse, WAIT_BLOCK until block_valid, then A0, A1, A2, A3, then squeeze_done.
- 4. out_len=3 with out_ready low for 2 cycles on each byte → out_byte held constant while stalled; exactly 3 handshakes; done after the third.
- 5. out_len=0 → squeeze_done on the second cycle after start; out_valid never asserted; busy high for exactly 1 cycle.
- 6. reset asserted in EMIT after 10 bytes → next cycle all outputs 0 and state IDLE; a subsequent out_len=2 squeeze emits block bytes 0 and 1 correctly.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared SHAKE256 definitions used by the absorb-side padder and the squeeze-side emitter.
package shake_pkg;

    localparam int RATE_BITS  = 1088;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        SQ_IDLE       = 3'd0,
        SQ_WAIT_BLOCK = 3'd1,
        SQ_EMIT       = 3'd2,
        SQ_REQ        = 3'd3,
        SQ_DONE       = 3'd4
    } sq_state_t;

endpackage

// File: rtl/shake_rate_byte_sel.sv
// Combinational byte selector over the rate block; byte 0 is the most significant byte.
module shake_rate_byte_sel
    import shake_pkg::*;
#(
    parameter int RANGE = RATE_BITS,
    parameter int IDX_W = $clog2(RANGE / 8)
) (
    input  logic [RANGE-1:0] block,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       byte_out
);

    // Indices past the last byte select zero rather than wrapping into the block.
    always_comb begin
        byte_out = 8'h00;
        for (int k = 0; k < RANGE / 8; k++) begin
            if (idx == IDX_W'(k)) begin
                byte_out = block[RANGE-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/shake_squeeze.sv
// SHAKE256 squeeze stage: streams rate bytes out and asks for permutations until out_len bytes are sent.
module shake_squeeze
    import shake_pkg::*;
#(
    parameter int RANGE = RATE_BITS,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             squeeze_start,
    input  logic [LEN_W-1:0] out_len,
    input  logic [RANGE-1:0] block_in,
    input  logic             block_valid,
    output logic             perm_req,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             squeeze_done,
    output logic             busy,
    output logic [2:0]       debug_state,
    output logic [10:0]      debug_bytecount
);

    localparam int BYTES = RANGE / 8;
    localparam int IDX_W = $clog2(BYTES);

    sq_state_t        state, state_n;
    logic [RANGE-1:0] block_q;
    logic [LEN_W-1:0] remaining;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       next_byte;
    logic             hs;

    assign hs       = (state == SQ_EMIT) && out_valid && out_ready;
    assign idx_next = byte_idx + IDX_W'(1);

    shake_rate_byte_sel #(
        .RANGE (RANGE),
        .IDX_W (IDX_W)
    ) u_byte_sel (
        .block    (block_q),
        .idx      (idx_next),
        .byte_out (next_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SQ_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // End of output wins over end of block, so the final byte never triggers a permutation.
    always_comb begin
        state_n = state;
        case (state)
            SQ_IDLE: begin
                if (squeeze_start) begin
                    state_n = (out_len != '0) ? SQ_WAIT_BLOCK : SQ_DONE;
                end
            end
            SQ_WAIT_BLOCK: begin
                if (block_valid) begin
                    state_n = SQ_EMIT;
                end
            end
            SQ_EMIT: begin
                if (hs) begin
                    if (remaining == LEN_W'(1)) begin
                        state_n = SQ_DONE;
                    end else if (byte_idx == IDX_W'(BYTES - 1)) begin
                        state_n = SQ_REQ;
                    end
                end
            end
            SQ_REQ:  state_n = SQ_WAIT_BLOCK;
            SQ_DONE: state_n = SQ_IDLE;
            default: state_n = SQ_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_req        <= 1'b0;
            squeeze_done    <= 1'b0;
            busy            <= 1'b0;
            debug_state     <= 3'd0;
            out_valid       <= 1'b0;
            out_byte        <= 8'h00;
            debug_bytecount <= 11'd0;
            block_q         <= '0;
            remaining       <= '0;
            byte_idx        <= '0;
        end else begin
            perm_req     <= (state_n == SQ_REQ);
            squeeze_done <= (state_n == SQ_DONE);
            busy         <= (state_n != SQ_IDLE);
            debug_state  <= state_n;
            case (state)
                SQ_IDLE: begin
                    if (squeeze_start && (out_len != '0)) begin
                        remaining <= out_len;
                    end
                end
                SQ_WAIT_BLOCK: begin
                    if (block_valid) begin
                        block_q         <= block_in;
                        byte_idx        <= '0;
                        debug_bytecount <= 11'd0;
                        out_byte        <= block_in[RANGE-1 -: 8];
                        out_valid       <= 1'b1;
                    end
                end
                SQ_EMIT: begin
                    if (hs) begin
                        remaining       <= remaining - LEN_W'(1);
                        byte_idx        <= idx_next;
                        debug_bytecount <= debug_bytecount + 11'd1;
                        if (state_n == SQ_EMIT) begin
                            out_byte <= next_byte;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze: directed squeezes, a negedge monitor pops expected bytes.
module tb_shake_squeeze;

    localparam int RANGE = 1088;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             squeeze_start;
    logic [LEN_W-1:0] out_len;
    logic [RANGE-1:0] block_in;
    logic             block_valid;
    logic             perm_req;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             squeeze_done;
    logic             busy;
    logic [2:0]       debug_state;
    logic [10:0]      debug_bytecount;

    int n_vec = 0;
    int n_err = 0;
    int perm_count = 0;
    int done_count = 0;
    int hs_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    shake_squeeze #(.RANGE(RANGE), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .squeeze_start   (squeeze_start),
        .out_len         (out_len),
        .block_in        (block_in),
        .block_valid     (block_valid),
        .perm_req        (perm_req),
        .out_byte        (out_byte),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .squeeze_done    (squeeze_done),
        .busy            (busy),
        .debug_state     (debug_state),
        .debug_bytecount (debug_bytecount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: 80, 00 x131, 1F 63 62 61; mode 1: byte k = k; mode 2: byte k = A0+k
    function automatic logic [7:0] exp_byte(input int mode, input int k);
        logic [7:0] b;
        case (mode)
            0: begin
                case (k)
                    0:       b = 8'h80;
                    132:     b = 8'h1F;
                    133:     b = 8'h63;
                    134:     b = 8'h62;
                    135:     b = 8'h61;
                    default: b = 8'h00;
                endcase
            end
            1:       b = 8'(k);
            default: b = 8'(8'hA0 + k);
        endcase
        return b;
    endfunction

    function automatic logic [RANGE-1:0] mk_block(input int mode);
        logic [RANGE-1:0] blk = '0;
        for (int k = 0; k < RANGE / 8; k++) blk[RANGE-1-8*k -: 8] = exp_byte(mode, k);
        return blk;
    endfunction

    // Monitor: sample mid-cycle, pop on handshake, check held byte while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            if (perm_req) perm_count++;
            if (squeeze_done) done_count++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, out_byte}, 32'hFFFF_FFFF);
                end else if (out_ready) begin
                    check("byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
                    hs_count++;
                end else begin
                    check("stall_hold", {24'h0, out_byte}, {24'h0, exp_q[0]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        out_len = LEN_W'(len);
        squeeze_start = 1'b1;
        tick();
        squeeze_start = 1'b0;
    endtask

    task automatic give_block(input int mode);
        int n = 0;
        while (debug_state != 3'd1 && n < 50) begin
            tick();
            n++;
        end
        check("reach_wait_block", {29'h0, debug_state}, 32'd1);
        block_in = mk_block(mode);
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!squeeze_done && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    task automatic push_bytes(input int mode, input int first, input int count);
        for (int k = first; k < first + count; k++) exp_q.push_back(exp_byte(mode, k));
    endtask

    initial begin
        int cyc;
        int p0;
        int d0;
        int h0;
        reset = 1'b1;
        squeeze_start = 1'b0;
        out_len = '0;
        block_in = '0;
        block_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_state", {29'h0, debug_state}, 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: 4 bytes of the padded-looking block
        p0 = perm_count;
        exp_q.push_back(8'h80); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        start(4);
        check("t1_busy", {31'h0, busy}, 32'd1);
        give_block(0);
        wait_done(cyc);
        check("t1_done_latency", cyc, 4);
        check("t1_busy_in_done", {31'h0, busy}, 32'd1);
        tick();
        check("t1_done_pulse", {31'h0, squeeze_done}, 32'd0);
        check("t1_idle", {31'h0, busy}, 32'd0);
        check("t1_perm", perm_count - p0, 0);
        check("t1_q_empty", exp_q.size(), 0);

        // Test 2: whole block, no permutation request
        p0 = perm_count;
        d0 = done_count;
        push_bytes(0, 0, 136);
        start(136);
        give_block(0);
        wait_done(cyc);
        check("t2_done_latency", cyc, 136);
        check("t2_bytecount", {21'h0, debug_bytecount}, 32'd136);
        tick();
        tick();
        check("t2_perm", perm_count - p0, 0);
        check("t2_done_once", done_count - d0, 1);
        check("t2_q_empty", exp_q.size(), 0);

        // Test 3: spans two blocks
        p0 = perm_count;
        push_bytes(1, 0, 136);
        push_bytes(2, 0, 4);
        start(140);
        give_block(1);
        cyc = 0;
        while (debug_state != 3'd3 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t3_req_at", cyc, 136);
        check("t3_perm_req", {31'h0, perm_req}, 32'd1);
        tick();
        check("t3_perm_pulse", {31'h0, perm_req}, 32'd0);
        tick();
        tick();
        check("t3_waiting", {29'h0, debug_state}, 32'd1);
        check("t3_no_valid", {31'h0, out_valid}, 32'd0);
        give_block(2);
        wait_done(cyc);
        check("t3_done_latency", cyc, 4);
        tick();
        check("t3_perm_count", perm_count - p0, 1);
        check("t3_q_empty", exp_q.size(), 0);

        // Test 4: two stall cycles on each byte
        h0 = hs_count;
        out_ready = 1'b0;
        push_bytes(1, 0, 3);
        start(3);
        give_block(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("t4_done", {31'h0, squeeze_done}, 32'd1);
        check("t4_handshakes", hs_count - h0, 3);
        out_ready = 1'b1;
        tick();
        check("t4_q_empty", exp_q.size(), 0);

        // Test 5: zero-length squeeze
        start(0);
        check("t5_done", {31'h0, squeeze_done}, 32'd1);
        check("t5_busy", {31'h0, busy}, 32'd1);
        check("t5_no_valid", {31'h0, out_valid}, 32'd0);
        tick();
        check("t5_done_pulse", {31'h0, squeeze_done}, 32'd0);
        check("t5_busy_off", {31'h0, busy}, 32'd0);

        // Test 6: reset mid-emit, then a short squeeze
        push_bytes(1, 0, 20);
        start(20);
        give_block(1);
        for (int i = 0; i < 10; i++) tick();
        check("t6_bytecount", {21'h0, debug_bytecount}, 32'd10);
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        exp_q.delete();
        check("t6_valid", {31'h0, out_valid}, 32'd0);
        check("t6_byte", {24'h0, out_byte}, 32'd0);
        check("t6_busy", {31'h0, busy}, 32'd0);
        check("t6_perm", {31'h0, perm_req}, 32'd0);
        check("t6_done", {31'h0, squeeze_done}, 32'd0);
        check("t6_state", {29'h0, debug_state}, 32'd0);
        check("t6_count", {21'h0, debug_bytecount}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        push_bytes(2, 0, 2);
        start(2);
        give_block(2);
        wait_done(cyc);
        check("t6_done_latency", cyc, 2);
        tick();
        check("t6_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
